idct_pe_param: RTL and testbench

Parametrised systolic multiply-accumulate processing element for the IDCT array. It computes one output coefficient as a dot product of an N-lane skewed input vector with a runtime-programmable coefficient row. It then applies rounding offset, arithmetic shift and optional saturation. Input lanes are forwarded with one-cycle delay to the neighbouring PE. This block generalises the fixed-coefficient, 8-point, unqualified-data element: it adds N/width parameters, a coefficient load port, valid tracking and saturation.

---
 rtl/idct_pe_param.sv | 154 +++++++++++++++
 tb/tb_idct_pe_param.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_pe_param.sv
`default_nettype none
// ============================================================================
//  Module   : idct_pe_param
//  Purpose  : Parametrised systolic multiply-accumulate PE for the IDCT array.
//             It computes one output coefficient as the dot product of an
//             N-lane skewed input vector with a programmable coefficient row.
//             It then adds a rounding offset, applies an arithmetic right
//             shift and optionally saturates. Input lanes are forwarded to the
//             neighbouring PE with a one-cycle delay.
//  Ports    : clk, reset           - rising-edge clock, async active-high reset
//             d_in, in_valid       - skewed lane data; in_valid marks lane 0
//             coef_wr_*            - coefficient RAM write port
//             add, shift, sat_en   - output rounding / scaling / clamp control
//             d_out, out_valid     - result and its one-cycle valid pulse
//             sat_hit              - result was clamped
//             d_prop, prop_valid   - one-cycle delayed copy of d_in/in_valid
//  Revision : 1.0  initial release
// ============================================================================
module idct_pe_param #(
  parameter int N     = 8,
  parameter int DW    = 25,
  parameter int CW    = 8,
  parameter int ACC_W = 40,
  parameter int OUT_W = 25,
  parameter int SH_W  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N*DW-1:0]         d_in,
  input  logic                    in_valid,
  input  logic                    coef_wr_en,
  input  logic [$clog2(N)-1:0]    coef_wr_addr,
  input  logic [CW-1:0]           coef_wr_data,
  input  logic [ACC_W-1:0]        add,
  input  logic [SH_W-1:0]         shift,
  input  logic                    sat_en,
  output logic [OUT_W-1:0]        d_out,
  output logic                    out_valid,
  output logic                    sat_hit,
  output logic [N*DW-1:0]         d_prop,
  output logic                    prop_valid
);

  localparam int AW = $clog2(N);
  localparam int PW = DW + CW;

  // Output clamp limits expressed at accumulator width so the compare is a
  // plain signed comparison against the shifted result.
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Coefficient RAM and stage registers
  logic signed [CW-1:0]    coef_q [0:N-1];
  logic signed [ACC_W-1:0] acc_q  [0:N-2];
  logic signed [ACC_W-1:0] acc_d  [0:N-2];
  logic        [N-2:0]     v_q;

  logic [OUT_W-1:0]        d_out_q;
  logic [OUT_W-1:0]        d_out_d;
  logic                    sat_hit_q;
  logic                    sat_hit_d;
  logic                    out_valid_q;
  logic [N*DW-1:0]         d_prop_q;
  logic                    prop_valid_q;

  logic signed [ACC_W-1:0] w_prod [0:N-1];
  logic signed [ACC_W-1:0] w_final;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shr;

  // Per-lane product, sign-extended to accumulator width
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic signed [DW-1:0] w_lane;
    logic signed [PW-1:0] w_mul;
    assign w_lane    = d_in[k*DW +: DW];
    assign w_mul     = w_lane * coef_q[k];
    assign w_prod[k] = {{(ACC_W-PW){w_mul[PW-1]}}, w_mul};
  end

  always_comb begin
    acc_d[0] = w_prod[0];
    for (int k = 1; k < N-1; k++) begin
      acc_d[k] = acc_q[k-1] + w_prod[k];
    end
  end

  // Last lane is folded in combinationally so the result registers in the
  // same cycle lane N-1 is presented.
  assign w_final = acc_q[N-2] + w_prod[N-1];
  assign w_sum   = w_final + $signed(add);
  assign w_shr   = w_sum >>> shift;

  always_comb begin
    d_out_d   = w_shr[OUT_W-1:0];
    sat_hit_d = 1'b0;
    if (sat_en) begin
      if (w_shr > OUT_MAX) begin
        d_out_d   = OUT_MAX[OUT_W-1:0];
        sat_hit_d = 1'b1;
      end else if (w_shr < OUT_MIN) begin
        d_out_d   = OUT_MIN[OUT_W-1:0];
        sat_hit_d = 1'b1;
      end
    end
  end

  // Datapath: stage accumulators and coefficient RAM. A write lands at the
  // edge, so a stage using the same index this cycle still sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N-1; k++) acc_q[k] <= '0;
      for (int k = 0; k < N; k++)   coef_q[k] <= '0;
    end else begin
      for (int k = 0; k < N-1; k++) acc_q[k] <= acc_d[k];
      for (int k = 0; k < N; k++) begin
        if (coef_wr_en && (coef_wr_addr == AW'(k))) begin
          coef_q[k] <= coef_wr_data;
        end
      end
    end
  end

  // Control: valid pipeline, result registers and lane forwarding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q          <= '0;
      d_out_q      <= '0;
      sat_hit_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      d_prop_q     <= '0;
      prop_valid_q <= 1'b0;
    end else begin
      v_q[0] <= in_valid;
      for (int k = 1; k < N-1; k++) v_q[k] <= v_q[k-1];
      out_valid_q <= v_q[N-2];
      if (v_q[N-2]) begin
        d_out_q   <= d_out_d;
        sat_hit_q <= sat_hit_d;
      end
      d_prop_q     <= d_in;
      prop_valid_q <= in_valid;
    end
  end

  assign d_out      = d_out_q;
  assign sat_hit    = sat_hit_q;
  assign out_valid  = out_valid_q;
  assign d_prop     = d_prop_q;
  assign prop_valid = prop_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_idct_pe_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idct_pe_param
//  Purpose  : Directed self-checking bench for idct_pe_param (N=8 main
//             instance plus an N=3 instance for out-of-range coefficient
//             addresses).
//  Revision : 1.0  initial release
// ============================================================================
module tb_idct_pe_param;
  localparam int N     = 8;
  localparam int DW    = 25;
  localparam int CW    = 8;
  localparam int ACC_W = 40;
  localparam int OUT_W = 25;
  localparam int SH_W  = 5;
  localparam int AW    = $clog2(N);

  localparam int N2     = 3;
  localparam int DW2    = 8;
  localparam int ACC_W2 = 20;
  localparam int OUT_W2 = 16;
  localparam int SH_W2  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [N*DW-1:0]   d_in;
  logic              in_valid;
  logic              coef_wr_en;
  logic [AW-1:0]     coef_wr_addr;
  logic [CW-1:0]     coef_wr_data;
  logic [ACC_W-1:0]  add;
  logic [SH_W-1:0]   shift;
  logic              sat_en;
  logic [OUT_W-1:0]  d_out;
  logic              out_valid;
  logic              sat_hit;
  logic [N*DW-1:0]   d_prop;
  logic              prop_valid;

  logic [N2*DW2-1:0] d_in2;
  logic              in_valid2;
  logic              coef_wr_en2;
  logic [1:0]        coef_wr_addr2;
  logic [CW-1:0]     coef_wr_data2;
  logic [OUT_W2-1:0] d_out2;
  logic              out_valid2;
  logic              sat_hit2;
  logic [N2*DW2-1:0] d_prop2;
  logic              prop_valid2;

  idct_pe_param #(.N(N), .DW(DW), .CW(CW), .ACC_W(ACC_W), .OUT_W(OUT_W), .SH_W(SH_W)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .in_valid(in_valid),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .add(add), .shift(shift), .sat_en(sat_en),
    .d_out(d_out), .out_valid(out_valid), .sat_hit(sat_hit),
    .d_prop(d_prop), .prop_valid(prop_valid)
  );

  idct_pe_param #(.N(N2), .DW(DW2), .CW(CW), .ACC_W(ACC_W2), .OUT_W(OUT_W2), .SH_W(SH_W2)) dut2 (
    .clk(clk), .reset(reset), .d_in(d_in2), .in_valid(in_valid2),
    .coef_wr_en(coef_wr_en2), .coef_wr_addr(coef_wr_addr2), .coef_wr_data(coef_wr_data2),
    .add('0), .shift('0), .sat_en(1'b1),
    .d_out(d_out2), .out_valid(out_valid2), .sat_hit(sat_hit2),
    .d_prop(d_prop2), .prop_valid(prop_valid2)
  );

  int checks = 0;
  int errors = 0;

  int     cf [8] = '{64, -75, 36, 18, -64, 89, -83, 50};
  int     vals [16];
  longint exp_out [16];
  bit     exp_sat [16];
  int     wr_cycle = -1;
  int     wr_addr  = 0;
  int     wr_data  = 0;
  logic [N*DW-1:0] exp_prop;
  logic            exp_pv;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coef(input int idx, input int val);
    coef_wr_en   = 1'b1;
    coef_wr_addr = AW'(idx);
    coef_wr_data = CW'(val);
    tick();
    coef_wr_en   = 1'b0;
  endtask

  task automatic load_all(input int c0, input int c1, input int c2, input int c3,
                          input int c4, input int c5, input int c6, input int c7);
    load_coef(0, c0); load_coef(1, c1); load_coef(2, c2); load_coef(3, c3);
    load_coef(4, c4); load_coef(5, c5); load_coef(6, c6); load_coef(7, c7);
  endtask

  // Skewed feed: in cycle t lane k carries vector (t-k) of the burst
  task automatic set_lanes(input int t, input int m);
    for (int k = 0; k < N; k++) begin
      int j;
      j = t - k;
      d_in[k*DW +: DW] = (j >= 0 && j < m) ? DW'(vals[j]) : '0;
    end
    in_valid = (t < m);
  endtask

  task automatic run_burst(input int m, input string tag);
    for (int t = 0; t < m + N; t++) begin
      int j;
      set_lanes(t, m);
      if (t == wr_cycle) begin
        coef_wr_en   = 1'b1;
        coef_wr_addr = AW'(wr_addr);
        coef_wr_data = CW'(wr_data);
      end else begin
        coef_wr_en = 1'b0;
      end
      tick();
      j = t + 1 - N;
      if (j >= 0 && j < m) begin
        chk($sformatf("%s_valid%0d", tag, j), longint'(out_valid), 1);
        chk($sformatf("%s_dout%0d", tag, j), longint'($signed(d_out)), exp_out[j]);
        chk($sformatf("%s_sat%0d", tag, j), longint'(sat_hit), longint'(exp_sat[j]));
      end else begin
        chk($sformatf("%s_idle_t%0d", tag, t), longint'(out_valid), 0);
      end
    end
    coef_wr_en = 1'b0;
    wr_cycle   = -1;
    in_valid   = 1'b0;
    d_in       = '0;
  endtask

  initial begin
    reset = 1'b1;
    d_in = '0; in_valid = 1'b0;
    coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
    add = '0; shift = '0; sat_en = 1'b1;
    d_in2 = '0; in_valid2 = 1'b0;
    coef_wr_en2 = 1'b0; coef_wr_addr2 = '0; coef_wr_data2 = '0;
    tick(); tick();

    // Reset state
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_d_out", longint'($signed(d_out)), 0);
    chk("rst_sat_hit", longint'(sat_hit), 0);
    chk("rst_prop_valid", longint'(prop_valid), 0);
    checks++;
    assert (d_prop === '0) else begin
      errors++;
      $error("FAIL rst_d_prop observed=%h expected=0", d_prop);
    end
    reset = 1'b0;
    tick();

    // Single vector, all lanes 100: 100*35=3500, (3500+64)>>>7 = 27
    load_all(cf[0], cf[1], cf[2], cf[3], cf[4], cf[5], cf[6], cf[7]);
    add = ACC_W'(64); shift = SH_W'(7); sat_en = 1'b1;
    vals[0] = 100; exp_out[0] = 27; exp_sat[0] = 1'b0;
    run_burst(1, "single");

    // Eight back-to-back vectors, lanes = i -> 35*i each cycle
    add = '0; shift = '0;
    for (int i = 0; i < 8; i++) begin
      vals[i] = i + 1; exp_out[i] = 35 * (i + 1); exp_sat[i] = 1'b0;
    end
    run_burst(8, "b2b");

    // Saturation: 64*(2^23-1) = 2^29-64
    load_all(64, 0, 0, 0, 0, 0, 0, 0);
    vals[0] = 8388607; exp_out[0] = 16777215; exp_sat[0] = 1'b1;
    sat_en = 1'b1;
    run_burst(1, "sat_on");
    vals[0] = 8388607; exp_out[0] = -64; exp_sat[0] = 1'b0;
    sat_en = 1'b0;
    run_burst(1, "sat_off");
    sat_en = 1'b1;

    // Mid-flight write of coef[5]=0 in cycle c+3: 35-89 = -54
    load_all(cf[0], cf[1], cf[2], cf[3], cf[4], cf[5], cf[6], cf[7]);
    vals[0] = 1; exp_out[0] = -54; exp_sat[0] = 1'b0;
    wr_cycle = 3; wr_addr = 5; wr_data = 0;
    run_burst(1, "midwr");

    // Reset with three vectors in flight, asserted in cycle c+4
    load_all(cf[0], cf[1], cf[2], cf[3], cf[4], cf[5], cf[6], cf[7]);
    vals[0] = 1; vals[1] = 2; vals[2] = 3;
    for (int t = 0; t < 4; t++) begin
      set_lanes(t, 3);
      tick();
    end
    set_lanes(4, 3);
    reset = 1'b1;
    #1;
    chk("arst_out_valid", longint'(out_valid), 0);
    chk("arst_d_out", longint'($signed(d_out)), 0);
    chk("arst_sat_hit", longint'(sat_hit), 0);
    chk("arst_prop_valid", longint'(prop_valid), 0);
    checks++;
    assert (d_prop === '0) else begin
      errors++;
      $error("FAIL arst_d_prop observed=%h expected=0", d_prop);
    end
    tick();
    in_valid = 1'b0; d_in = '0;
    reset = 1'b0;
    for (int t = 0; t < N + 2; t++) begin
      tick();
      chk($sformatf("arst_stale_t%0d", t), longint'(out_valid), 0);
    end
    // Coefficients cleared: lanes 100 contribute nothing, only add=5 remains
    add = ACC_W'(5); shift = '0;
    vals[0] = 100; exp_out[0] = 5; exp_sat[0] = 1'b0;
    run_burst(1, "coef_clr");
    add = '0;

    // N=3 instance: address 3 is outside the coefficient row and ignored
    coef_wr_en2 = 1'b1;
    coef_wr_addr2 = 2'd0; coef_wr_data2 = 8'd1; tick();
    coef_wr_addr2 = 2'd1; coef_wr_data2 = 8'd2; tick();
    coef_wr_addr2 = 2'd2; coef_wr_data2 = 8'd3; tick();
    coef_wr_addr2 = 2'd3; coef_wr_data2 = 8'd100; tick();
    coef_wr_en2 = 1'b0;
    d_in2 = {8'd1, 8'd1, 8'd1};
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    chk("n3_idle1", longint'(out_valid2), 0);
    tick();
    chk("n3_idle2", longint'(out_valid2), 0);
    tick();
    chk("n3_valid", longint'(out_valid2), 1);
    chk("n3_dout", longint'($signed(d_out2)), 6);
    chk("n3_sat", longint'(sat_hit2), 0);
    d_in2 = '0;

    // Lane forwarding with random data
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < N; k++) d_in[k*DW +: DW] = DW'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      exp_prop = d_in;
      exp_pv   = in_valid;
      tick();
      checks++;
      assert (d_prop === exp_prop) else begin
        errors++;
        $error("FAIL d_prop_t%0d observed=%h expected=%h", t, d_prop, exp_prop);
      end
      chk($sformatf("prop_valid_t%0d", t), longint'(prop_valid), longint'(exp_pv));
    end
    in_valid = 1'b0;
    d_in = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
